// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall sequencer: load-use stalls, branch flushes and a data-memory
// wait FSM with timeout, plus saturating stall/flush statistics.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       rs_if_id,
  input  logic [4:0]       rt_if_id,
  input  logic [4:0]       rt_id_ex,
  input  logic             ctrl_memRead_id_ex,
  input  logic             ctrl_branch_ex_mem,
  input  logic             zero_ex_mem,
  input  logic             ctrl_memRead_ex_mem,
  input  logic             ctrl_memWrite_ex_mem,
  input  logic             dmem_ready,
  output logic             dmem_req,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             id_ex_bubble,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             flush_ex_mem,
  output logic             pipe_hold,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  // Last wait-counter value before the next not-ready cycle hits the timeout.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_t state_q, state_d;

  logic              mem_access;
  logic              branch_taken;
  logic              load_use;
  logic              eval_hazards;
  logic              stall_inc;
  logic              flush_inc;
  logic              wait_inc;
  logic              wait_clr;
  logic [WAIT_W-1:0] wait_cnt;

  assign mem_access   = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
  assign branch_taken = ctrl_branch_ex_mem & zero_ex_mem;
  assign load_use     = ctrl_memRead_id_ex && (rt_id_ex != REG_ZERO) &&
                        ((rt_id_ex == rs_if_id) || (rt_id_ex == rt_if_id));

  always_comb begin
    state_d      = state_q;
    dmem_req     = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_bubble = 1'b0;
    flush_if_id  = 1'b0;
    flush_id_ex  = 1'b0;
    flush_ex_mem = 1'b0;
    pipe_hold    = 1'b0;
    mem_error    = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    wait_inc     = 1'b0;
    wait_clr     = 1'b0;
    eval_hazards = 1'b0;

    case (state_q)
      RUN: begin
        dmem_req = mem_access;
        if (mem_access && !dmem_ready) begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          wait_clr    = 1'b1;
          state_d     = MEM_WAIT;
        end else begin
          eval_hazards = 1'b1;
        end
      end
      MEM_WAIT: begin
        dmem_req  = 1'b1;
        stall_inc = 1'b1;
        wait_inc  = 1'b1;
        if (dmem_ready) begin
          eval_hazards = 1'b1;
          state_d      = RUN;
        end else begin
          pipe_hold   = 1'b1;
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          if (wait_cnt == WAIT_LAST) begin
            state_d = ERROR;
          end
        end
      end
      ERROR: begin
        pipe_hold   = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        mem_error   = 1'b1;
      end
      default: begin
        state_d = RUN;
      end
    endcase

    // Branch flush outranks load-use: the stalled instruction is squashed anyway.
    if (eval_hazards) begin
      if (branch_taken) begin
        flush_if_id  = 1'b1;
        flush_id_ex  = 1'b1;
        flush_ex_mem = 1'b1;
        flush_inc    = 1'b1;
      end else if (load_use) begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
        stall_inc    = 1'b1;
      end
    end

    // While reset is low the outputs show idle values, aborting any access at once.
    if (!reset) begin
      dmem_req     = 1'b0;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_bubble = 1'b0;
      flush_if_id  = 1'b0;
      flush_id_ex  = 1'b0;
      flush_ex_mem = 1'b0;
      pipe_hold    = 1'b0;
      mem_error    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (stall_inc),
    .clr   (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (flush_inc),
    .clr   (1'b0),
    .count (flush_count)
  );

  sat_counter #(.W(WAIT_W)) u_wait_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (wait_inc),
    .clr   (wait_clr),
    .count (wait_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed plus randomized bench for pipeline_hazard_ctrl against a cycle-level
// behavioural model of the hazard rules.
module tb_pipeline_hazard_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [4:0]    rs_if_id, rt_if_id, rt_id_ex;
  logic          ctrl_memRead_id_ex, ctrl_branch_ex_mem, zero_ex_mem;
  logic          ctrl_memRead_ex_mem, ctrl_memWrite_ex_mem, dmem_ready;
  logic          dmem_req, pc_write, if_id_write, id_ex_bubble;
  logic          flush_if_id, flush_id_ex, flush_ex_mem, pipe_hold, mem_error;
  logic [CW-1:0] stall_count, flush_count;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.CNT_W(CW), .MEM_TIMEOUT(TO)) dut (
    .clk                  (clk),
    .reset                (reset),
    .rs_if_id             (rs_if_id),
    .rt_if_id             (rt_if_id),
    .rt_id_ex             (rt_id_ex),
    .ctrl_memRead_id_ex   (ctrl_memRead_id_ex),
    .ctrl_branch_ex_mem   (ctrl_branch_ex_mem),
    .zero_ex_mem          (zero_ex_mem),
    .ctrl_memRead_ex_mem  (ctrl_memRead_ex_mem),
    .ctrl_memWrite_ex_mem (ctrl_memWrite_ex_mem),
    .dmem_ready           (dmem_ready),
    .dmem_req             (dmem_req),
    .pc_write             (pc_write),
    .if_id_write          (if_id_write),
    .id_ex_bubble         (id_ex_bubble),
    .flush_if_id          (flush_if_id),
    .flush_id_ex          (flush_id_ex),
    .flush_ex_mem         (flush_ex_mem),
    .pipe_hold            (pipe_hold),
    .mem_error            (mem_error),
    .stall_count          (stall_count),
    .flush_count          (flush_count)
  );

  int total = 0;
  int bad   = 0;

  // Model: waiting on memory, stuck in error, length of the current not-ready run.
  bit m_wait, m_err;
  int m_run, m_stall, m_flush;
  bit fire_br, fire_lu;
  logic e_req, e_pcw, e_ifw, e_bub, e_fif, e_fid, e_fex, e_hold, e_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_wait = 0; m_err = 0; m_run = 0; m_stall = 0; m_flush = 0;
  endtask

  task automatic model_outputs();
    bit mem, br, lu;
    mem = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    br  = ctrl_branch_ex_mem & zero_ex_mem;
    lu  = ctrl_memRead_id_ex && (rt_id_ex != 0) &&
          (rt_id_ex == rs_if_id || rt_id_ex == rt_if_id);
    fire_br = 0; fire_lu = 0;
    e_req = 0; e_pcw = 1; e_ifw = 1; e_bub = 0;
    e_fif = 0; e_fid = 0; e_fex = 0; e_hold = 0; e_err = 0;
    if (!reset) begin
      // idle values while reset is asserted
    end else if (m_err) begin
      e_hold = 1; e_pcw = 0; e_ifw = 0; e_err = 1;
    end else if (!dmem_ready && (m_wait || mem)) begin
      e_hold = 1; e_req = 1; e_pcw = 0; e_ifw = 0;
    end else begin
      e_req = m_wait | mem;
      if (br) begin
        e_fif = 1; e_fid = 1; e_fex = 1; fire_br = 1;
      end else if (lu) begin
        e_pcw = 0; e_ifw = 0; e_bub = 1; fire_lu = 1;
      end
    end
  endtask

  task automatic model_edge();
    bit mem;
    mem = ctrl_memRead_ex_mem | ctrl_memWrite_ex_mem;
    if (!reset) return;
    if (((m_wait && !m_err) || fire_lu) && m_stall < CMAX) m_stall++;
    if (fire_br && m_flush < CMAX) m_flush++;
    if (m_err) begin
      // sticky until reset
    end else if (m_wait) begin
      if (dmem_ready) m_wait = 0;
      else begin
        m_run++;
        if (m_run == TO + 1) begin m_err = 1; m_wait = 0; end
      end
    end else if (mem && !dmem_ready) begin
      m_wait = 1; m_run = 1;
    end
  endtask

  task automatic check_outputs();
    model_outputs();
    chk("dmem_req",     dmem_req,     e_req);
    chk("pc_write",     pc_write,     e_pcw);
    chk("if_id_write",  if_id_write,  e_ifw);
    chk("id_ex_bubble", id_ex_bubble, e_bub);
    chk("flush_if_id",  flush_if_id,  e_fif);
    chk("flush_id_ex",  flush_id_ex,  e_fid);
    chk("flush_ex_mem", flush_ex_mem, e_fex);
    chk("pipe_hold",    pipe_hold,    e_hold);
    chk("mem_error",    mem_error,    e_err);
    chk("stall_count",  stall_count,  m_stall);
    chk("flush_count",  flush_count,  m_flush);
  endtask

  // One clock: inputs already set at a falling edge; check, advance, return at next falling edge.
  task automatic step();
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rs_if_id = 0; rt_if_id = 0; rt_id_ex = 0;
    ctrl_memRead_id_ex = 0; ctrl_branch_ex_mem = 0; zero_ex_mem = 0;
    ctrl_memRead_ex_mem = 0; ctrl_memWrite_ex_mem = 0; dmem_ready = 0;
  endtask

  task automatic do_reset();
    reset = 0;
    model_reset();
    #1;
    check_outputs();
    @(negedge clk);
    reset = 1;
  endtask

  initial begin
    clear_inputs();
    reset = 0;
    model_reset();
    #2;
    check_outputs();
    @(negedge clk);
    reset = 1;
    step();

    // Load-use stall, then the rt=0 exemption.
    ctrl_memRead_id_ex = 1; rt_id_ex = 5'd8; rs_if_id = 5'd8;
    step();
    clear_inputs();
    #1 chk("stall_after_loaduse", stall_count, 1);
    step();
    ctrl_memRead_id_ex = 1; rt_id_ex = 5'd0; rs_if_id = 5'd0;
    step();

    // Branch taken together with a load-use hazard.
    ctrl_memRead_id_ex = 1; rt_id_ex = 5'd9; rt_if_id = 5'd9;
    ctrl_branch_ex_mem = 1; zero_ex_mem = 1;
    step();
    clear_inputs();
    #1 chk("flush_after_branch", flush_count, 1);
    step();

    // Memory read ready on the fourth cycle.
    ctrl_memRead_ex_mem = 1;
    repeat (3) step();
    dmem_ready = 1;
    step();
    clear_inputs();
    #1 chk("stall_after_memwait", stall_count, 4);
    step();

    // Timeout into ERROR, sticky until reset.
    ctrl_memWrite_ex_mem = 1;
    repeat (TO + 1) step();
    #1 chk("error_raised", mem_error, 1);
    chk("error_no_req", dmem_req, 0);
    dmem_ready = 1;
    repeat (3) step();
    do_reset();
    clear_inputs();
    step();

    // Reset in the second MEM_WAIT cycle.
    ctrl_memRead_ex_mem = 1;
    repeat (2) step();
    #1 chk("hold_before_abort", pipe_hold, 1);
    reset = 0;
    model_reset();
    #1 chk("req_abort", dmem_req, 0);
    chk("hold_abort", pipe_hold, 0);
    @(negedge clk);
    reset = 1;
    ctrl_memRead_ex_mem = 0;
    step();

    // Counter saturation.
    ctrl_memRead_id_ex = 1; rt_id_ex = 5'd3; rs_if_id = 5'd3;
    repeat (CMAX + 4) step();
    #1 chk("stall_saturated", stall_count, CMAX);
    clear_inputs();
    ctrl_branch_ex_mem = 1; zero_ex_mem = 1;
    repeat (CMAX + 4) step();
    #1 chk("flush_saturated", flush_count, CMAX);
    clear_inputs();
    do_reset();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      rs_if_id             = 5'($urandom_range(0, 3));
      rt_if_id             = 5'($urandom_range(0, 3));
      rt_id_ex             = 5'($urandom_range(0, 3));
      ctrl_memRead_id_ex   = ($urandom_range(0, 1) == 1);
      ctrl_branch_ex_mem   = ($urandom_range(0, 3) == 0);
      zero_ex_mem          = ($urandom_range(0, 1) == 1);
      ctrl_memRead_ex_mem  = ($urandom_range(0, 3) == 0);
      ctrl_memWrite_ex_mem = ($urandom_range(0, 5) == 0);
      dmem_ready           = ($urandom_range(0, 4) < 3);
      if ($urandom_range(0, 39) == 0) do_reset();
      else step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end

endmodule
